aes_key_expand: RTL and testbench

- Iterative AES-128 key-schedule engine. Takes a 128-bit cipher key and emits the 11 round keys (rounds 0..10) in order, one per accepted handshake.
- Sits between the key-load interface and the round datapath.
- Internally instantiates the codebase's R_con lookup, driving its 4-bit round input from the round counter and consuming its 32-bit rcon output.
- Contains four combinational AES S-box byte lookups for SubWord.

---
 rtl/aes_key_expand.sv | 202 ++++++++++++++++++++
 tb/tb_aes_key_expand.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule. It emits round keys 0..NR,
// one key per rk_valid/rk_ready handshake.
// Optional macro KEY_EXP_STORE_EN adds an 11x128 store of emitted keys,
// read through rd_addr/rd_key.
// Ports:
//   clk, rst_n           : rising-edge clock, synchronous active-low reset
//   start, key_in        : begin expansion of key_in (accepted only when idle)
//   rk_valid, rk_ready   : round-key handshake
//   rk, rk_round         : current round key (w0 at [127:96]) and its index
//   busy, done           : expansion in progress / one-cycle completion pulse
//   rd_addr, rd_key      : stored-key read port (zero when the store is absent)
module aes_key_expand #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  localparam int unsigned KW = 128;
  localparam int unsigned RW = 4;
  localparam int unsigned WW = 32;
  localparam int unsigned NK = 11;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_rk;
  logic [KW-1:0]   w_rk_nxt;
  logic [RW-1:0]   r_round;
  logic [RW-1:0]   w_round_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_busy;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_load;

  logic [RW-1:0]   w_rcon_round;
  logic [WW-1:0]   w_rcon;
  logic [WW-1:0]   w_rot;
  logic [WW-1:0]   w_sub;
  logic [WW-1:0]   w_t;
  logic [WW-1:0]   w_w0n;
  logic [WW-1:0]   w_w1n;
  logic [WW-1:0]   w_w2n;
  logic [WW-1:0]   w_w3n;

  // Round constant for the key about to be generated.
  assign w_rcon_round = RW'(r_round + RW'(1));

  R_con u_rcon (
    .i_round (w_rcon_round),
    .o_rcon  (w_rcon)
  );

  // Next-key datapath: RotWord, SubWord, rcon, then the w0..w3 XOR chain.
  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_t   = w_sub ^ w_rcon;
  assign w_w0n = r_rk[127:96] ^ w_t;
  assign w_w1n = r_rk[95:64]  ^ w_w0n;
  assign w_w2n = r_rk[63:32]  ^ w_w1n;
  assign w_w3n = r_rk[31:0]   ^ w_w2n;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rk    <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rk    <= w_rk_nxt;
      r_round <= w_round_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt == ST_EMIT);
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; rk/rk_round only move on load or handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_rk_nxt    = r_rk;
    w_round_nxt = r_round;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_EMIT;
          w_rk_nxt    = key_in;
          w_round_nxt = '0;
          w_valid_nxt = 1'b1;
          w_load      = 1'b1;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (r_round == RW'(NR)) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_rk_nxt    = {w_w0n, w_w1n, w_w2n, w_w3n};
            w_round_nxt = w_rcon_round;
            w_load      = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rk_valid = r_valid;
  assign rk       = r_rk;
  assign rk_round = r_round;
  assign busy     = r_busy;
  assign done     = r_done;

`ifdef KEY_EXP_STORE_EN
  logic [KW-1:0] r_store [NK];

  // Each key is stored in the same cycle it is loaded onto rk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NK); i++) r_store[i] <= '0;
    end else if (w_load) begin
      r_store[w_round_nxt] <= w_rk_nxt;
    end
  end

  assign rd_key = (rd_addr < RW'(NK)) ? r_store[rd_addr] : '0;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_addr;
  assign rd_key      = '0;
`endif

endmodule

// R_con: AES round constant {rc, 24'h0} for rounds 1..10; zero otherwise.
module R_con (
  input  logic [3:0]  i_round,
  output logic [31:0] o_rcon
);
  always_comb begin
    o_rcon = '0;
    case (i_round)
      4'd1:    o_rcon = 32'h0100_0000;
      4'd2:    o_rcon = 32'h0200_0000;
      4'd3:    o_rcon = 32'h0400_0000;
      4'd4:    o_rcon = 32'h0800_0000;
      4'd5:    o_rcon = 32'h1000_0000;
      4'd6:    o_rcon = 32'h2000_0000;
      4'd7:    o_rcon = 32'h4000_0000;
      4'd8:    o_rcon = 32'h8000_0000;
      4'd9:    o_rcon = 32'h1b00_0000;
      4'd10:   o_rcon = 32'h3600_0000;
      default: o_rcon = '0;
    endcase
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand (FIPS-197 key schedule).
module tb_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_key   (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] key;
  } vec_t;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  vec_t vecs [11];
  vec_t exp_q [$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic         hold_pending = 1'b0;
  logic [127:0] hold_rk;
  logic [3:0]   hold_round;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected key on each handshake, checks hold under backpressure.
  always @(negedge clk) begin
    vec_t e;
    if (hold_pending) begin
      check("hold_rk", rk, hold_rk);
      check("hold_round", 128'(rk_round), 128'(hold_round));
      hold_pending = 1'b0;
    end
    if (rk_valid && rk_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_key", 128'(rk_round), 128'hffff);
      end else begin
        e = exp_q.pop_front();
        check("sb_round", 128'(rk_round), 128'(e.round));
        check("sb_rk", rk, e.key);
      end
    end else if (rk_valid) begin
      hold_pending = 1'b1;
      hold_rk      = rk;
      hold_round   = rk_round;
    end
    if (done) done_cnt++;
  end

  // Start an expansion of the FIPS key and queue its 11 expected round keys.
  task automatic run_start();
    start  = 1'b1;
    key_in = FIPS_KEY;
    for (int i = 0; i < 11; i++) exp_q.push_back(vecs[i]);
    @(posedge clk); #1;
    start  = 1'b0;
    check("latency_valid", 128'(rk_valid), 128'(1));
    check("latency_round", 128'(rk_round), 128'(0));
    check("latency_busy", 128'(busy), 128'(1));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 200);
    check("done_seen", 128'(done), 128'(1));
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (!(rk_valid && rk_round == r) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("round_reached", 128'(rk_round), 128'(r));
  endtask

  task automatic check_store(input string tag);
    for (int a = 0; a < 16; a++) begin
      logic [127:0] exp_k;
      rd_addr = 4'(a);
      #1;
`ifdef KEY_EXP_STORE_EN
      exp_k = (a < 11) ? vecs[a].key : '0;
`else
      exp_k = '0;
`endif
      check(tag, rd_key, exp_k);
    end
    rd_addr = '0;
  endtask

  initial begin
    int cyc;
    logic pat [4];
    vecs[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      check("idle_valid", 128'(rk_valid), 128'(0));
      check("idle_busy", 128'(busy), 128'(0));
      check("idle_done", 128'(done), 128'(0));
      check("idle_rk", rk, 128'(0));
      @(posedge clk); #1;
    end

    // FIPS-197 key at full throughput.
    rk_ready = 1'b1;
    run_start();
    wait_done(cyc);
    check("start_to_done", 128'(cyc + 1), 128'(12));
    check("queue_empty1", 128'(exp_q.size()), 128'(0));
    check("done_cnt1", 128'(done_cnt), 128'(0));
    check("done_busy", 128'(busy), 128'(0));
    check("done_valid", 128'(rk_valid), 128'(0));
    @(posedge clk); #1;
    check("done_pulse", 128'(done), 128'(0));
    check("done_cnt1b", 128'(done_cnt), 128'(1));
    check("retain_rk", rk, vecs[10].key);
    check("retain_round", 128'(rk_round), 128'(10));
    check_store("store_fips");

    // Backpressure with rk_ready 1,0,0,1,...
    run_start();
    cyc = 0;
    while (!done && cyc < 200) begin
      rk_ready = pat[cyc % 4];
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_done", 128'(done), 128'(1));
    rk_ready = 1'b1;
    @(posedge clk); #1;
    check("queue_empty2", 128'(exp_q.size()), 128'(0));
    check("done_cnt2", 128'(done_cnt), 128'(2));

    // Start while busy is ignored.
    run_start();
    wait_round(4'd4);
    start = 1'b1; key_in = OTHER_KEY;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("busy_start_final", rk, vecs[10].key);
    @(posedge clk); #1;
    check("busy_start_idle", 128'(busy), 128'(0));
    check("queue_empty3", 128'(exp_q.size()), 128'(0));
    check("done_cnt3", 128'(done_cnt), 128'(3));

    // Reset mid-expansion.
    run_start();
    wait_round(4'd6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mrst_valid", 128'(rk_valid), 128'(0));
    check("mrst_busy", 128'(busy), 128'(0));
    check("mrst_done", 128'(done), 128'(0));
    check("mrst_rk", rk, 128'(0));
    rd_addr = 4'd0;
    #1 check("mrst_store", rd_key, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("mrst_no_done", 128'(done), 128'(0));
    end
    check("done_cnt4", 128'(done_cnt), 128'(3));

    // Fresh start, then a back-to-back start in the done cycle.
    run_start();
    wait_done(cyc);
    check("fresh_to_done", 128'(cyc + 1), 128'(12));
    run_start();
    wait_done(cyc);
    check("b2b_to_done", 128'(cyc + 1), 128'(12));
    @(posedge clk); #1;
    check("queue_empty5", 128'(exp_q.size()), 128'(0));
    check("done_cnt5", 128'(done_cnt), 128'(5));
    check_store("store_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
